// File: rtl/mem_stage.sv
// Pipeline memory stage: issues loads/stores, stalls upstream until done,
// extends load data, and aborts hung accesses through a sticky watchdog.

package util;
    function automatic logic [31:0] sext(input logic [31:0] data, input int unsigned bits);
        logic [31:0] sh;
        sh = 32 - bits;
        return $signed(data << sh) >>> sh;
    endfunction
endpackage

package core;
    localparam logic [6:0] opcode_load  = 7'b0000011;
    localparam logic [6:0] opcode_store = 7'b0100011;

    typedef struct packed {
        logic        valid;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] ex_result;
        logic [31:0] ex_addr;
        logic [31:0] rs2_value;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [31:0] ex_result;
        logic [31:0] mem_result;
    } mem_wb_t;

    localparam mem_wb_t mem_wb_rst = '0;
endpackage

package sys;
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
    } mem_read_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic        done;
    } mem_read_rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
        logic        en;
    } mem_write_req_t;

    typedef struct packed {
        logic done;
    } mem_write_rsp_t;

    localparam mem_read_req_t  mem_read_req_rst  = '0;
    localparam mem_write_req_t mem_write_req_rst = '0;
endpackage

module mem_stage #(
    parameter int unsigned timeout_cycles = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  core::ex_mem_t       ex_mem_in,
    output logic                stall_out,
    output core::mem_wb_t       mem_wb_out,
    output logic                mem_read_en,
    output sys::mem_read_req_t  mem_read_req,
    input  sys::mem_read_rsp_t  mem_read_rsp,
    output sys::mem_write_req_t mem_write_req,
    input  sys::mem_write_rsp_t mem_write_rsp,
    output logic                mem_fault
);

    typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT} state_t;

    state_t        state;
    core::mem_wb_t hold;
    logic [31:0]   wd_cnt;
    logic          wd_expired;

    // log2 byte size; the unsigned load variants share the signed encodings
    function automatic logic [1:0] size_of(input logic is_store, input logic [2:0] f3);
        case (f3)
            3'b000:  return 2'd0;
            3'b001:  return 2'd1;
            3'b100:  return is_store ? 2'd2 : 2'd0;
            3'b101:  return is_store ? 2'd2 : 2'd1;
            default: return 2'd2;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] data);
        case (f3)
            3'b000:  return util::sext(data, 8);
            3'b001:  return util::sext(data, 16);
            3'b100:  return {24'd0, data[7:0]};
            3'b101:  return {16'd0, data[15:0]};
            default: return data;
        endcase
    endfunction

    function automatic core::mem_wb_t to_wb(input core::ex_mem_t ex);
        return '{valid: 1'b1, opcode: ex.opcode, funct3: ex.funct3, rd: ex.rd,
                 ex_result: ex.ex_result, mem_result: 32'd0};
    endfunction

    assign stall_out  = (state != IDLE);
    assign wd_expired = (timeout_cycles != 0) && (wd_cnt == 32'(timeout_cycles - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            hold          <= core::mem_wb_rst;
            wd_cnt        <= '0;
            mem_wb_out    <= core::mem_wb_rst;
            mem_read_en   <= 1'b0;
            mem_read_req  <= sys::mem_read_req_rst;
            mem_write_req <= sys::mem_write_req_rst;
            mem_fault     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (!ex_mem_in.valid) begin
                        mem_wb_out.valid <= 1'b0;
                    end else if (ex_mem_in.opcode == core::opcode_load) begin
                        hold             <= to_wb(ex_mem_in);
                        mem_read_en      <= 1'b1;
                        mem_read_req     <= '{addr: ex_mem_in.ex_addr,
                                              size: size_of(1'b0, ex_mem_in.funct3)};
                        mem_wb_out.valid <= 1'b0;
                        state            <= LOAD_WAIT;
                    end else if (ex_mem_in.opcode == core::opcode_store) begin
                        hold             <= to_wb(ex_mem_in);
                        mem_write_req    <= '{addr: ex_mem_in.ex_addr,
                                              size: size_of(1'b1, ex_mem_in.funct3),
                                              data: ex_mem_in.rs2_value, en: 1'b1};
                        mem_wb_out.valid <= 1'b0;
                        state            <= STORE_WAIT;
                    end else begin
                        mem_wb_out <= to_wb(ex_mem_in);
                    end
                end
                LOAD_WAIT: begin
                    if (mem_read_rsp.done) begin
                        mem_wb_out            <= hold;
                        mem_wb_out.mem_result <= load_ext(hold.funct3, mem_read_rsp.data);
                        mem_read_en           <= 1'b0;
                        state                 <= IDLE;
                    end else if (wd_expired) begin
                        mem_read_en      <= 1'b0;
                        mem_fault        <= 1'b1;
                        mem_wb_out.valid <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
                end
                STORE_WAIT: begin
                    if (mem_write_rsp.done) begin
                        mem_wb_out       <= hold;
                        mem_write_req.en <= 1'b0;
                        state            <= IDLE;
                    end else if (wd_expired) begin
                        mem_write_req.en <= 1'b0;
                        mem_fault        <= 1'b1;
                        mem_wb_out.valid <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: scoreboarded writeback output plus direct
// checks of request, stall and fault signals.

module tb_mem_stage;

    logic                clk;
    logic                rst;
    core::ex_mem_t       ex_mem_in;
    logic                stall_out;
    core::mem_wb_t       mem_wb_out;
    logic                mem_read_en;
    sys::mem_read_req_t  mem_read_req;
    sys::mem_read_rsp_t  mem_read_rsp;
    sys::mem_write_req_t mem_write_req;
    sys::mem_write_rsp_t mem_write_rsp;
    logic                mem_fault;

    int n_cmp = 0;
    int n_bad = 0;
    core::mem_wb_t sb[$];

    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_ADD  = 7'b0110011;

    mem_stage #(.timeout_cycles(4)) dut (
        .clk(clk), .rst(rst), .ex_mem_in(ex_mem_in), .stall_out(stall_out),
        .mem_wb_out(mem_wb_out), .mem_read_en(mem_read_en), .mem_read_req(mem_read_req),
        .mem_read_rsp(mem_read_rsp), .mem_write_req(mem_write_req),
        .mem_write_rsp(mem_write_rsp), .mem_fault(mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one edge, then sample and score any writeback output
    task automatic step();
        @(posedge clk);
        #1;
        if (mem_wb_out.valid === 1'b1) begin
            if (sb.size() == 0) chk("sb_unexpected_valid", {79'd0, mem_wb_out.valid}, 80'd0);
            else                chk("sb_out", mem_wb_out, sb.pop_front());
        end
    endtask

    function automatic core::ex_mem_t mk_ex(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [4:0] rd, input logic [31:0] res,
                                            input logic [31:0] addr, input logic [31:0] rs2);
        return '{valid: 1'b1, opcode: op, funct3: f3, rd: rd, ex_result: res,
                 ex_addr: addr, rs2_value: rs2};
    endfunction

    function automatic core::mem_wb_t exp_wb(input core::ex_mem_t ex, input logic [31:0] res);
        return '{valid: 1'b1, opcode: ex.opcode, funct3: ex.funct3, rd: ex.rd,
                 ex_result: ex.ex_result, mem_result: res};
    endfunction

    function automatic logic [31:0] model_ext(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b100:  return {24'h000000, d[7:0]};
            3'b101:  return {16'h0000, d[15:0]};
            default: return d;
        endcase
    endfunction

    // load with done arriving 'delay' wait cycles after the request appears
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input int delay, input logic [1:0] exp_size,
                           input core::ex_mem_t nxt);
        core::ex_mem_t ex;
        ex = mk_ex(core::opcode_load, f3, 5'd7, addr ^ 32'h0F0F, addr, 32'h5555_AAAA);
        sb.push_back(exp_wb(ex, model_ext(f3, data)));
        ex_mem_in = ex;
        step();
        chk({tag, "_read_en"}, {79'd0, mem_read_en}, 80'd1);
        chk({tag, "_read_req"}, {46'd0, mem_read_req}, {46'd0, addr, exp_size});
        chk({tag, "_stall_req"}, {79'd0, stall_out}, 80'd1);
        for (int i = 1; i < delay; i++) begin
            step();
            chk({tag, "_stall_wait"}, {79'd0, stall_out}, 80'd1);
            chk({tag, "_no_out_wait"}, {79'd0, mem_wb_out.valid}, 80'd0);
        end
        mem_read_rsp = '{data: data, done: 1'b1};
        step();
        mem_read_rsp = '{data: 32'hBAD0_BAD0, done: 1'b0};
        ex_mem_in = nxt;
        chk({tag, "_emitted"}, 80'(sb.size()), 80'd0);
        chk({tag, "_read_en_off"}, {79'd0, mem_read_en}, 80'd0);
        chk({tag, "_stall_off"}, {79'd0, stall_out}, 80'd0);
    endtask

    initial begin
        core::ex_mem_t ex;
        core::ex_mem_t idle_ex;

        idle_ex       = '0;
        ex_mem_in     = '0;
        mem_read_rsp  = '0;
        mem_write_rsp = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_wb_out", mem_wb_out, core::mem_wb_rst);
        chk("rst_read_en", {79'd0, mem_read_en}, 80'd0);
        chk("rst_write_en", {79'd0, mem_write_req.en}, 80'd0);
        chk("rst_stall", {79'd0, stall_out}, 80'd0);
        chk("rst_fault", {79'd0, mem_fault}, 80'd0);

        // pass-through
        ex = mk_ex(OP_ADDI, 3'b000, 5'd5, 32'h1234, 32'h0, 32'h0);
        sb.push_back(exp_wb(ex, 32'd0));
        ex_mem_in = ex;
        step();
        chk("pass_emitted", 80'(sb.size()), 80'd0);
        chk("pass_stall", {79'd0, stall_out}, 80'd0);
        ex_mem_in = idle_ex;
        step();
        chk("pass_bubble", {79'd0, mem_wb_out.valid}, 80'd0);

        // loads with various extensions
        do_load("lb",  3'b000, 32'h100, 32'h0000_00F0, 2, 2'd0, idle_ex);
        do_load("lbu", 3'b100, 32'h104, 32'h0000_00F0, 2, 2'd0, idle_ex);
        do_load("lh",  3'b001, 32'h108, 32'h0000_8001, 1, 2'd1, idle_ex);
        do_load("lhu", 3'b101, 32'h10C, 32'h1234_8001, 3, 2'd1, idle_ex);
        do_load("lw",  3'b010, 32'h110, 32'hCAFE_F00D, 1, 2'd2, idle_ex);
        step();

        // store with done in the request cycle
        ex = mk_ex(core::opcode_store, 3'b010, 5'd0, 32'h0, 32'h200, 32'hDEAD_BEEF);
        sb.push_back(exp_wb(ex, 32'd0));
        ex_mem_in = ex;
        step();
        chk("sw_write_req", {13'd0, mem_write_req}, {13'd0, 32'h200, 2'd2, 32'hDEAD_BEEF, 1'b1});
        chk("sw_stall", {79'd0, stall_out}, 80'd1);
        mem_write_rsp.done = 1'b1;
        step();
        mem_write_rsp.done = 1'b0;
        ex_mem_in = idle_ex;
        chk("sw_emitted", 80'(sb.size()), 80'd0);
        chk("sw_write_en_off", {79'd0, mem_write_req.en}, 80'd0);
        chk("sw_stall_off", {79'd0, stall_out}, 80'd0);
        step();

        // back-to-back: ADD waiting behind a load
        ex = mk_ex(OP_ADD, 3'b000, 5'd9, 32'h77, 32'h0, 32'h0);
        do_load("b2b_lb", 3'b000, 32'h180, 32'h0000_007F, 1, 2'd0, ex);
        sb.push_back(exp_wb(ex, 32'd0));
        step();
        chk("b2b_add_emitted", 80'(sb.size()), 80'd0);
        chk("b2b_add_valid", {79'd0, mem_wb_out.valid}, 80'd1);
        ex_mem_in = idle_ex;
        step();
        chk("b2b_no_dup", {79'd0, mem_wb_out.valid}, 80'd0);

        // watchdog abort with timeout_cycles=4
        ex_mem_in = mk_ex(core::opcode_load, 3'b000, 5'd3, 32'h0, 32'h300, 32'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wd_read_en_held", {79'd0, mem_read_en}, 80'd1);
            chk("wd_fault_early", {79'd0, mem_fault}, 80'd0);
        end
        step();
        ex_mem_in = idle_ex;
        chk("wd_read_en_off", {79'd0, mem_read_en}, 80'd0);
        chk("wd_fault_set", {79'd0, mem_fault}, 80'd1);
        chk("wd_stall_off", {79'd0, stall_out}, 80'd0);
        chk("wd_no_out", {79'd0, mem_wb_out.valid}, 80'd0);
        mem_read_rsp = '{data: 32'h1111_1111, done: 1'b1};
        step();
        mem_read_rsp = '0;
        chk("wd_late_done_ignored", {79'd0, mem_wb_out.valid}, 80'd0);
        chk("wd_fault_sticky", {79'd0, mem_fault}, 80'd1);

        ex = mk_ex(OP_ADDI, 3'b000, 5'd6, 32'hABCD, 32'h0, 32'h0);
        sb.push_back(exp_wb(ex, 32'd0));
        ex_mem_in = ex;
        step();
        ex_mem_in = idle_ex;
        chk("post_fault_pass", 80'(sb.size()), 80'd0);
        chk("post_fault_sticky", {79'd0, mem_fault}, 80'd1);

        // reset during STORE_WAIT
        ex_mem_in = mk_ex(core::opcode_store, 3'b001, 5'd0, 32'h0, 32'h400, 32'h0000_BEEF);
        step();
        chk("rstw_write_req", {13'd0, mem_write_req}, {13'd0, 32'h400, 2'd1, 32'h0000_BEEF, 1'b1});
        rst = 1'b1;
        ex_mem_in = idle_ex;
        step();
        rst = 1'b0;
        chk("rstw_write_en", {79'd0, mem_write_req.en}, 80'd0);
        chk("rstw_stall", {79'd0, stall_out}, 80'd0);
        chk("rstw_wb_out", mem_wb_out, core::mem_wb_rst);
        chk("rstw_fault_cleared", {79'd0, mem_fault}, 80'd0);
        mem_write_rsp.done = 1'b1;
        step();
        chk("rstw_late_done", {79'd0, mem_wb_out.valid}, 80'd0);
        mem_write_rsp.done = 1'b0;
        step();
        chk("rstw_idle", {79'd0, stall_out}, 80'd0);
        chk("sb_drained", 80'(sb.size()), 80'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline memory stage; sits between the execute stage (consumes core::ex_mem_t) and writeback (produces core::mem_wb_t).
- Issues load/store requests on the sys memory read/write interfaces and waits for completion, stalling upstream meanwhile.
- Applies load size selection and sign/zero extension.
- Has a watchdog that aborts a hung access and flags a sticky fault.

Parameters:
- timeout_cycles, 256: maximum cycles in a wait state before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_mem_in  in  core::ex_mem_t  execute-stage output register; held stable by upstream while stall_out=1
- stall_out  out  1  upstream must hold ex_mem_in
- mem_wb_out  out  core::mem_wb_t  registered output to writeback
- mem_read_en  out  1  read request valid
- mem_read_req  out  sys::mem_read_req_t  read address/size
- mem_read_rsp  in  sys::mem_read_rsp_t  read data; done=1 means complete
- mem_write_req  out  sys::mem_write_req_t  write addr/size/data; en = request valid
- mem_write_rsp  in  sys::mem_write_rsp_t  done=1 means write complete
- mem_fault  out  1  sticky; watchdog expired

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst.
- Reset values: state IDLE; mem_wb_out = core::mem_wb_rst; mem_read_en=0; mem_read_req = mem_read_req_rst; mem_write_req = mem_write_req_rst; mem_fault=0; watchdog counter=0.
- stall_out = (state != IDLE). It is purely state-decoded, with no combinational path from rsp.done.
- Memory op decode: opcode_load → load; opcode_store → store; any other opcode → pass-through.
- IDLE, ex_mem_in.valid=0: mem_wb_out.valid←0 next edge.
- IDLE, valid pass-through:
  - Next edge mem_wb_out ← fields copied from ex_mem_in, mem_result=0, valid=1. Latency 1.
- IDLE, valid load:
  - Capture ex_mem_in into a hold register.
  - Register mem_read_en=1 and mem_read_req = {ex_addr, size}.
  - Go LOAD_WAIT; mem_wb_out.valid←0.
- IDLE, valid store:
  - Capture ex_mem_in.
  - Register mem_write_req = {ex_addr, size, rs2_value, en=1}.
  - Go STORE_WAIT; mem_wb_out.valid←0.
- Size encoding is log2 bytes:
  - lb/lbu/sb → 0
  - lh/lhu/sh → 1
  - lw/sw and any undefined funct3 → 2
- The address is passed unmodified; no misalignment check.
- Request outputs are held constant for the whole wait state.
- LOAD_WAIT, mem_read_rsp.done=1 (earliest the cycle after capture):
  - Next edge mem_wb_out ← hold register with mem_result = extended data, valid=1.
  - mem_read_en←0; state IDLE.
- Load extension, with data right-aligned:
  - lb → util::sext(data,8)
  - lh → util::sext(data,16)
  - lbu → zero-extend bits 7:0
  - lhu → zero-extend bits 15:0
  - lw and undefined funct3 → data unchanged
- STORE_WAIT, mem_write_rsp.done=1:
  - Next edge mem_wb_out ← hold register, mem_result=0, valid=1.
  - mem_write_req.en←0; state IDLE.
- A done seen in IDLE, or on the interface not being waited on, is ignored.
- Watchdog:
  - Counter cleared on entry to a wait state; increments each wait cycle without done.
  - When counter == timeout_cycles-1 and done=0: next edge state IDLE, request en outputs 0, mem_fault←1, mem_wb_out.valid←0 (the instruction is dropped).
  - mem_fault stays 1 until rst. done wins over timeout in the same cycle.
- Minimum load/store occupancy is 3 cycles: capture, request with done, emit. stall_out is 1 from the cycle after capture through the done cycle inclusive.
- The next instruction is accepted in the first IDLE cycle; one bubble per memory op is expected.
- Reset mid-wait: drops the outstanding request (en outputs 0 next edge), clears the hold register and counter, and returns to IDLE. A late done is then ignored.

Test Plan:
- Pass-through: valid ADDI with ex_result=0x1234 → next cycle mem_wb_out.valid=1, ex_result=0x1234, mem_result=0; stall_out never 1.
- Load sign-extend: lb at ex_addr=0x100, memory returns data=0x000000F0 with done 2 cycles after request → mem_read_req={0x100,0}, stall_out=1 for 2 cycles, then mem_wb_out.mem_result=0xFFFFFFF0; same with lbu → 0x000000F0; lh with 0x00008001 → 0xFFFF8001.
- Store: sw rs2_value=0xDEADBEEF, ex_addr=0x200, done same cycle as request → mem_write_req={0x200,2,0xDEADBEEF,1} for exactly 1 cycle; mem_wb_out.valid=1 with mem_result=0 two cycles after capture.
- Back-to-back: load followed by ADD held in ex_mem_in → ADD emitted exactly one cycle after the load's mem_wb_out; no instruction lost or duplicated.
- Watchdog: timeout_cycles=4, load with done never asserted → after 4 wait cycles mem_read_en=0, mem_fault=1, state IDLE, no valid mem_wb_out; later done ignored; mem_fault cleared only by rst.
- Reset mid-wait: rst asserted during STORE_WAIT → next cycle mem_write_req.en=0, stall_out=0, mem_wb_out=mem_wb_rst; a done arriving afterwards produces no output.
